// File: rtl/req_enc_pkg.sv
// Shared constants and helpers for the request encoder: the default request
// count, the derived code width and a constant-foldable clog2.
package req_enc_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  localparam int DEFAULT_N = 4;
  localparam int CODE_W    = clog2(DEFAULT_N);

endpackage

// File: rtl/req_encoder_q_prio_enc.sv
// Combinational priority encoder: reports the index of the highest set bit of
// vec and whether any bit is set.
module prio_enc
  import req_enc_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
    any = |vec;
  end

endmodule

// File: rtl/req_encoder_q.sv
// Queues one-hot request events as a pending bit set and presents them one at
// a time, highest index first, as binary codes on a valid/ready output slot.
module req_encoder_q
  import req_enc_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overrun
);

  // Handshake: a code transfers on any rising edge where out_valid && out_ready.
  // While out_valid is high and out_ready low, out_code/out_valid are frozen.
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] out_code_q, out_code_d;
  logic         out_valid_q, out_valid_d;
  logic         overrun_q, overrun_d;

  logic [N-1:0] cand;
  logic [N-1:0] clr_mask;
  logic [W-1:0] enc_idx;
  logic         enc_any;
  logic         load;

  assign cand = pending_q | req;

  prio_enc #(.N(N)) u_prio_enc (
    .vec (cand),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    load        = !out_valid_q || out_ready;
    clr_mask    = {{(N-1){1'b0}}, 1'b1} << enc_idx;
    pending_d   = cand;
    out_code_d  = out_code_q;
    out_valid_d = out_valid_q;
    // A req bit landing on an already-pending bit is merged, even if that bit
    // is the one being moved into the slot this cycle.
    overrun_d   = |(req & pending_q);
    if (load) begin
      if (enc_any) begin
        out_code_d  = enc_idx;
        out_valid_d = 1'b1;
        pending_d   = cand & ~clr_mask;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      out_code_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_code_q  <= out_code_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_req_encoder_q.sv
// Directed bench for req_encoder_q: reset, single, burst order, stall/overrun,
// re-request, overrun-on-load and mid-run reset scenarios.
module tb_req_encoder_q;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [1:0] out_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] pending;
  logic       overrun;

  int tests_run;
  int tests_failed;

  req_encoder_q dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, then settle before sampling outputs.
  task automatic step(input logic [3:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b1);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, out_valid); end
      tests_run++; if (out_code !== 2'd0) begin tests_failed++; $display("FAIL reset_code cyc=%0d got=%0d exp=0", i, out_code); end
      tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL reset_pending cyc=%0d got=%b exp=0000", i, pending); end
      tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun cyc=%0d got=%b exp=0", i, overrun); end
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    step(4'b0010, 1'b1);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    tests_run++; if (out_code !== 2'd1) begin tests_failed++; $display("FAIL single_code got=%0d exp=1", out_code); end
    tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL single_pending got=%b exp=0000", pending); end
    step(4'b0000, 1'b1);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    tests_run++; if (out_code !== 2'd1) begin tests_failed++; $display("FAIL single_code_hold got=%0d exp=1", out_code); end
  endtask

  task automatic test_burst_order();
    logic [1:0] exp_code [3];
    logic [3:0] exp_pend [3];
    exp_code[0] = 2'd3; exp_pend[0] = 4'b0011;
    exp_code[1] = 2'd1; exp_pend[1] = 4'b0001;
    exp_code[2] = 2'd0; exp_pend[2] = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step((i == 0) ? 4'b1011 : 4'b0000, 1'b1);
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL burst_valid beat=%0d got=%b exp=1", i, out_valid); end
      tests_run++; if (out_code !== exp_code[i]) begin tests_failed++; $display("FAIL burst_code beat=%0d got=%0d exp=%0d", i, out_code, exp_code[i]); end
      tests_run++; if (pending !== exp_pend[i]) begin tests_failed++; $display("FAIL burst_pending beat=%0d got=%b exp=%b", i, pending, exp_pend[i]); end
    end
    step(4'b0000, 1'b1);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL burst_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) begin
      step((i == 0) ? 4'b1111 : 4'b0000, 1'b1);
      tests_run++; if (out_code !== 2'(3 - i)) begin tests_failed++; $display("FAIL simul_code beat=%0d got=%0d exp=%0d", i, out_code, 3 - i); end
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL simul_valid beat=%0d got=%b exp=1", i, out_valid); end
    end
    step(4'b0000, 1'b1);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL simul_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall_overrun();
    step(4'b0100, 1'b0);
    tests_run++; if (out_code !== 2'd2 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_load got=%0d/%b exp=2/1", out_code, out_valid); end
    step(4'b0001, 1'b0);
    tests_run++; if (pending !== 4'b0001) begin tests_failed++; $display("FAIL stall_pending1 got=%b exp=0001", pending); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL stall_no_overrun got=%b exp=0", overrun); end
    tests_run++; if (out_code !== 2'd2) begin tests_failed++; $display("FAIL stall_hold got=%0d exp=2", out_code); end
    step(4'b0001, 1'b0);
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL stall_overrun got=%b exp=1", overrun); end
    tests_run++; if (pending !== 4'b0001) begin tests_failed++; $display("FAIL stall_pending2 got=%b exp=0001", pending); end
    tests_run++; if (out_code !== 2'd2 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_hold2 got=%0d/%b exp=2/1", out_code, out_valid); end
    step(4'b0000, 1'b1);
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL overrun_pulse got=%b exp=0", overrun); end
    tests_run++; if (out_code !== 2'd0 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_release got=%0d/%b exp=0/1", out_code, out_valid); end
    tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL stall_release_pend got=%b exp=0000", pending); end
    step(4'b0000, 1'b1);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_rerequest();
    step(4'b1000, 1'b0);
    tests_run++; if (out_code !== 2'd3 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL rereq_load got=%0d/%b exp=3/1", out_code, out_valid); end
    step(4'b1000, 1'b0);
    tests_run++; if (pending !== 4'b1000) begin tests_failed++; $display("FAIL rereq_pending got=%b exp=1000", pending); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL rereq_overrun got=%b exp=0", overrun); end
    step(4'b0000, 1'b1);
    tests_run++; if (out_code !== 2'd3 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL rereq_second got=%0d/%b exp=3/1", out_code, out_valid); end
    tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL rereq_pend_clear got=%b exp=0000", pending); end
    step(4'b0000, 1'b1);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rereq_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_overrun_on_load();
    step(4'b1001, 1'b1);
    tests_run++; if (out_code !== 2'd3 || pending !== 4'b0001) begin tests_failed++; $display("FAIL ovl_first got=%0d/%b exp=3/0001", out_code, pending); end
    step(4'b0001, 1'b1);
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovl_overrun got=%b exp=1", overrun); end
    tests_run++; if (out_code !== 2'd0 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL ovl_code got=%0d/%b exp=0/1", out_code, out_valid); end
    tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL ovl_pending got=%b exp=0000", pending); end
    step(4'b0000, 1'b1);
    tests_run++; if (out_valid !== 1'b0 || overrun !== 1'b0) begin tests_failed++; $display("FAIL ovl_drain got=%b/%b exp=0/0", out_valid, overrun); end
  endtask

  task automatic test_mid_reset();
    step(4'b1000, 1'b0);
    step(4'b0110, 1'b0);
    tests_run++; if (pending !== 4'b0110 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_setup got=%b/%b exp=0110/1", pending, out_valid); end
    rst = 1'b1;
    step(4'b1111, 1'b1);
    rst = 1'b0;
    tests_run++; if (out_valid !== 1'b0 || pending !== 4'b0000 || out_code !== 2'd0) begin tests_failed++; $display("FAIL midrst_clear got=%b/%b/%0d exp=0/0000/0", out_valid, pending, out_code); end
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b1);
      tests_run++; if (out_valid !== 1'b0 || pending !== 4'b0000) begin tests_failed++; $display("FAIL midrst_idle cyc=%0d got=%b/%b exp=0/0000", i, out_valid, pending); end
    end
    step(4'b0100, 1'b1);
    tests_run++; if (out_code !== 2'd2 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_fresh got=%0d/%b exp=2/1", out_code, out_valid); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    req          = 4'b0000;
    out_ready    = 1'b0;
    test_reset();
    test_single();
    test_burst_order();
    test_simultaneous();
    test_stall_overrun();
    test_rerequest();
    test_overrun_on_load();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
